// File: rtl/signal_power_pkg.sv
// Shared widths, FSM encoding and helpers for the signal_power block.
// Imported by the top and the serial multiplier.
package signal_power_pkg;

  localparam int FFT_W     = 16;
  localparam int PWR_W     = 32;
  localparam int MULT_ITER = 16;
  localparam int CNT_W     = 5;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_RE_START = 3'd1,
    S_RE_WAIT  = 3'd2,
    S_IM_START = 3'd3,
    S_IM_WAIT  = 3'd4,
    S_OUT      = 3'd5
  } state_e;

  // Two's-complement magnitude as unsigned; 0x8000 maps to itself.
  function automatic logic [FFT_W-1:0] abs_u(
    input logic [FFT_W-1:0] x
  );
    logic [FFT_W-1:0] r;
    r = x[FFT_W-1] ? (~x + {{(FFT_W-1){1'b0}}, 1'b1}) : x;
    return r;
  endfunction

endpackage

// File: rtl/signal_power_mult.sv
// Unsigned 16x16->32 shift-add multiplier, one partial product per cycle.
// done pulses 16 cycles after start; product holds until the next start.
module serial_mult_u16
  import signal_power_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [FFT_W-1:0]     a,
  input  logic [FFT_W-1:0]     b,
  output logic                 done,
  output logic [PWR_W-1:0]     product
);

  logic [PWR_W-1:0] mcand_q, mcand_d;
  logic [FFT_W-1:0] mplier_q, mplier_d;
  logic [PWR_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [PWR_W-1:0] a_ext;

  assign a_ext = {{(PWR_W-FFT_W){1'b0}}, a};

  // First partial product is taken on the start edge so that the
  // sixteenth lands one cycle before done is presented.
  always_comb begin
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start && !busy_q) begin
      mcand_d  = a_ext << 1;
      mplier_d = b >> 1;
      acc_d    = b[0] ? a_ext : '0;
      cnt_d    = CNT_W'(1);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (mplier_q[0]) begin
        acc_d = acc_q + mcand_q;
      end
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CNT_W'(1);
      if (cnt_q == CNT_W'(MULT_ITER-1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign done    = done_q;
  assign product = acc_q;

endmodule

// File: rtl/signal_power.sv
// Squared magnitude re^2+im^2 of FFT bins, one bin in flight,
// both squares computed on a shared serial multiplier.
module signal_power
  import signal_power_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [FFT_W-1:0] fft_re,
  input  logic [FFT_W-1:0] fft_im,
  input  logic             fft_last,
  input  logic             fft_valid,
  output logic             fft_rdy,
  output logic [PWR_W-1:0] power_data,
  output logic             power_last,
  output logic             power_valid,
  input  logic             power_rdy
);

  state_e           state_q, state_d;
  logic [PWR_W-1:0] acc_q, acc_d;
  logic [FFT_W-1:0] re_q, re_d;
  logic [FFT_W-1:0] im_q, im_d;
  logic             last_q, last_d;
  logic             arm_q, arm_d;

  logic             mult_start;
  logic [FFT_W-1:0] mult_op;
  logic             mult_done;
  logic [PWR_W-1:0] mult_prod;
  logic             out_en;

  serial_mult_u16 u_mult (
    .clk     (clk),
    .rst     (rst),
    .start   (mult_start),
    .a       (mult_op),
    .b       (mult_op),
    .done    (mult_done),
    .product (mult_prod)
  );

  // arm_q keeps the input closed for the first cycle after reset.
  assign arm_d = 1'b1;

  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    re_d       = re_q;
    im_d       = im_q;
    last_d     = last_q;
    fft_rdy    = 1'b0;
    mult_start = 1'b0;
    mult_op    = re_q;
    unique case (state_q)
      S_IDLE: begin
        fft_rdy = fft_valid && arm_q && !rst;
        if (fft_rdy) begin
          re_d    = abs_u(fft_re);
          im_d    = abs_u(fft_im);
          last_d  = fft_last;
          state_d = S_RE_START;
        end
      end
      S_RE_START: begin
        mult_start = 1'b1;
        state_d    = S_RE_WAIT;
      end
      S_RE_WAIT: begin
        if (mult_done) begin
          acc_d   = mult_prod;
          state_d = S_IM_START;
        end
      end
      S_IM_START: begin
        mult_start = 1'b1;
        mult_op    = im_q;
        state_d    = S_IM_WAIT;
      end
      S_IM_WAIT: begin
        mult_op = im_q;
        if (mult_done) begin
          acc_d   = acc_q + mult_prod;
          state_d = S_OUT;
        end
      end
      S_OUT: begin
        if (power_rdy) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      re_q    <= '0;
      im_q    <= '0;
      last_q  <= 1'b0;
      arm_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      re_q    <= re_d;
      im_q    <= im_d;
      last_q  <= last_d;
      arm_q   <= arm_d;
    end
  end

  assign out_en      = (state_q == S_OUT) && !rst;
  assign power_valid = out_en;
  assign power_data  = out_en ? acc_q : '0;
  assign power_last  = out_en && last_q;

endmodule

// File: tb/tb_signal_power.sv
// Directed bench for signal_power: latency, values, backpressure,
// reset mid-flight and streaming cadence.
module tb_signal_power;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] fft_re;
  logic [15:0] fft_im;
  logic        fft_last;
  logic        fft_valid;
  logic        fft_rdy;
  logic [31:0] power_data;
  logic        power_last;
  logic        power_valid;
  logic        power_rdy;

  int cyc = 0;
  int total = 0;
  int bad = 0;

  signal_power dut (
    .clk         (clk),
    .rst         (rst),
    .fft_re      (fft_re),
    .fft_im      (fft_im),
    .fft_last    (fft_last),
    .fft_valid   (fft_valid),
    .fft_rdy     (fft_rdy),
    .power_data  (power_data),
    .power_last  (power_last),
    .power_valid (power_valid),
    .power_rdy   (power_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h",
             tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] re,
                      input logic [15:0] im,
                      input logic last,
                      output int t);
    fft_re    = re;
    fft_im    = im;
    fft_last  = last;
    fft_valid = 1'b1;
    #1;
    t = -1;
    for (int n = 0; n < 200; n++) begin
      if (fft_rdy) begin
        t = cyc;
        break;
      end
      tick();
      #1;
    end
    if (t < 0) chk("accept_timeout", {31'b0, fft_rdy}, 32'd1);
    tick();
    fft_valid = 1'b0;
    fft_re    = '0;
    fft_im    = '0;
    fft_last  = 1'b0;
  endtask

  task automatic wait_out(input int t_acc,
                          input logic [31:0] exp_d,
                          input logic exp_l,
                          input string tag);
    int   t;
    logic leak;
    t    = -1;
    leak = 1'b0;
    #1;
    for (int n = 0; n < 100; n++) begin
      if (power_valid) begin
        t = cyc;
        break;
      end
      leak = leak | (power_data != 0) | power_last;
      tick();
      #1;
    end
    chk({tag, "_valid"}, {31'b0, power_valid}, 32'd1);
    chk({tag, "_lat"}, 32'(t - t_acc), 32'd35);
    chk({tag, "_data"}, power_data, exp_d);
    chk({tag, "_last"}, {31'b0, power_last}, {31'b0, exp_l});
    chk({tag, "_idle0"}, {31'b0, leak}, 32'd0);
  endtask

  initial begin
    int   t;
    int   prev;
    logic seen;
    logic [15:0] s_re [4];
    logic [15:0] s_im [4];
    logic [31:0] s_p  [4];

    rst       = 1'b1;
    fft_re    = '0;
    fft_im    = '0;
    fft_last  = 1'b0;
    fft_valid = 1'b1;
    power_rdy = 1'b1;
    repeat (3) tick();
    #1;
    chk("rst_rdy", {31'b0, fft_rdy}, 32'd0);
    chk("rst_valid", {31'b0, power_valid}, 32'd0);
    chk("rst_data", power_data, 32'd0);
    chk("rst_last", {31'b0, power_last}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("post_rst_rdy", {31'b0, fft_rdy}, 32'd0);
    fft_valid = 1'b0;
    tick();

    send(16'd3, 16'd4, 1'b0, t);
    wait_out(t, 32'd25, 1'b0, "b34");
    tick();

    send(16'h8000, 16'h8000, 1'b1, t);
    wait_out(t, 32'h8000_0000, 1'b1, "bmax");
    tick();

    send(16'd0, 16'd0, 1'b0, t);
    wait_out(t, 32'd0, 1'b0, "bzero");
    tick();

    power_rdy = 1'b0;
    send(16'hFFFF, 16'h7FFF, 1'b0, t);
    wait_out(t, 32'h3FFF_0002, 1'b0, "bhold");
    fft_re    = 16'd1;
    fft_im    = 16'd1;
    fft_valid = 1'b1;
    #1;
    for (int k = 0; k < 10; k++) begin
      chk("hold_data", power_data, 32'h3FFF_0002);
      chk("hold_valid", {31'b0, power_valid}, 32'd1);
      chk("hold_rdy", {31'b0, fft_rdy}, 32'd0);
      tick();
      #1;
    end
    fft_valid = 1'b0;
    power_rdy = 1'b1;
    #1;
    chk("release_valid", {31'b0, power_valid}, 32'd1);
    tick();
    #1;
    chk("single_xfer", {31'b0, power_valid}, 32'd0);

    send(16'd100, 16'd0, 1'b0, t);
    repeat (9) tick();
    rst = 1'b1;
    #1;
    chk("midrst_valid", {31'b0, power_valid}, 32'd0);
    chk("midrst_data", power_data, 32'd0);
    tick();
    tick();
    rst  = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 60; k++) begin
      #1;
      seen = seen | power_valid;
      tick();
    end
    chk("discard", {31'b0, seen}, 32'd0);

    send(16'd5, 16'd12, 1'b0, t);
    wait_out(t, 32'd169, 1'b0, "b512");
    tick();

    s_re[0] = 16'd1;    s_im[0] = 16'd0; s_p[0] = 32'd1;
    s_re[1] = 16'd0;    s_im[1] = 16'd2; s_p[1] = 32'd4;
    s_re[2] = 16'hFFFD; s_im[2] = 16'd0; s_p[2] = 32'd9;
    s_re[3] = 16'd2;    s_im[3] = 16'd2; s_p[3] = 32'd8;
    prev = 0;
    for (int i = 0; i < 4; i++) begin
      send(s_re[i], s_im[i], (i == 3), t);
      if (i > 0) chk("stream_gap", 32'(t - prev), 32'd36);
      prev = t;
      wait_out(t, s_p[i], (i == 3), "stream");
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
